mod_n_counter: RTL and testbench

MOD_N_COUNTER -- requirements
Module: mod_n_counter

---
 rtl/mod_n_counter.sv | 72 +++++++
 tb/tb_mod_n_counter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with synchronous load and async active-low reset.
// Define MOD_N_COUNTER_TC_EN to drive o_tc; otherwise o_tc is tied low.
module mod_n_counter #(
    parameter int WIDTH = 2,
    parameter int N     = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up_down,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_Q,
    output logic             o_tc
);

    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0]    LP_N   = XW'(N);
    localparam logic [WIDTH-1:0] LP_NM1 = WIDTH'(N - 1);

    if (N < 2 || N > (2 ** WIDTH)) begin : g_bad_param
        $error("mod_n_counter: N must satisfy 2 <= N <= 2**WIDTH");
    end

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic [XW-1:0]    w_q_ext;
    logic [XW-1:0]    w_d_ext;
    logic [XW-1:0]    w_inc;
    logic [XW-1:0]    w_dec;
    logic             w_illegal;

    // Extra bit keeps N == 2**WIDTH from aliasing onto 0
    assign w_q_ext   = {1'b0, r_q};
    assign w_d_ext   = {1'b0, i_d};
    assign w_inc     = w_q_ext + XW'(1);
    assign w_dec     = w_q_ext - XW'(1);
    assign w_illegal = (w_q_ext >= LP_N);

    always_comb begin
        w_next = r_q;
        if (i_load) begin
            w_next = (w_d_ext < LP_N) ? i_d : '0;
        end else if (i_en) begin
            if (w_illegal) begin
                w_next = '0;
            end else if (i_up_down) begin
                w_next = (w_inc >= LP_N) ? '0 : w_inc[WIDTH-1:0];
            end else begin
                // Borrow out of the extended word means we were at 0
                w_next = w_dec[WIDTH] ? LP_NM1 : w_dec[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_Q = r_q;

`ifdef MOD_N_COUNTER_TC_EN
    assign o_tc = i_up_down ? (r_q == LP_NM1) : (r_q == '0);
`else
    assign o_tc = 1'b0;
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter (WIDTH=2, N=3): vector table plus
// hand-written reset sequences.
module tb_mod_n_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ud;
    logic       ld;
    logic [1:0] d;
    logic [1:0] q;
    logic       tc;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic       en;
        logic       ud;
        logic       ld;
        logic [1:0] d;
        logic [1:0] q;
    } vec_t;

    vec_t tbl[$];

    mod_n_counter #(.WIDTH(2), .N(3)) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_en      (en),
        .i_up_down (ud),
        .i_load    (ld),
        .i_d       (d),
        .o_Q       (q),
        .o_tc      (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_tc(input logic [1:0] eq, input logic eud);
`ifdef MOD_N_COUNTER_TC_EN
        return eud ? int'(eq == 2'd2) : int'(eq == 2'd0);
`else
        return 0;
`endif
    endfunction

    task automatic add(input logic e, input logic u, input logic l,
                       input logic [1:0] dd, input logic [1:0] eq);
        vec_t v;
        v.en = e; v.ud = u; v.ld = l; v.d = dd; v.q = eq;
        tbl.push_back(v);
    endtask

    task automatic step(input logic e, input logic u, input logic l,
                        input logic [1:0] dd);
        @(negedge clk);
        en = e; ud = u; ld = l; d = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // up x5
        add(1, 1, 0, 0, 1); add(1, 1, 0, 0, 2); add(1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 1); add(1, 1, 0, 0, 2);
        // down x4
        add(1, 0, 0, 0, 1); add(1, 0, 0, 0, 0); add(1, 0, 0, 0, 2);
        add(1, 0, 0, 0, 1);
        // hold x3 then up
        add(0, 1, 0, 0, 1); add(0, 0, 0, 0, 1); add(0, 1, 0, 0, 1);
        add(1, 1, 0, 0, 2);
        // loads: in range, out of range, load beats count
        add(0, 1, 1, 2, 2); add(0, 1, 1, 3, 0);
        add(1, 1, 1, 2, 2); add(1, 0, 1, 0, 0);
        // wrap down from 0, wrap up from 2
        add(1, 0, 0, 0, 2); add(1, 1, 0, 0, 0);
        // direction flip mid-run
        add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 0); add(1, 1, 0, 0, 1);

        rst_n = 1'b0; en = 1'b1; ud = 1'b0; ld = 1'b0; d = 2'd0;
        #2;
        check("reset_q", int'(q), 0);
        check("reset_tc", int'(tc), exp_tc(2'd0, 1'b0));
        @(posedge clk);
        #1;
        check("reset_hold_q", int'(q), 0);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].ud, tbl[i].ld, tbl[i].d);
            check($sformatf("vec%0d_q", i), int'(q), int'(tbl[i].q));
            check($sformatf("vec%0d_tc", i), int'(tc),
                  exp_tc(tbl[i].q, tbl[i].ud));
        end

        // Reset asserted between edges while counting
        step(1, 1, 0, 0);
        check("pre_rst_q", int'(q), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", int'(q), 0);
        ud = 1'b0;
        #1;
        check("async_rst_tc", int'(tc), exp_tc(2'd0, 1'b0));
        en = 1'b1; ld = 1'b1; d = 2'd2; ud = 1'b1;
        @(posedge clk);
        #1;
        check("rst_beats_load", int'(q), 0);
        @(posedge clk);
        #1;
        check("rst_beats_count", int'(q), 0);
        @(negedge clk);
        rst_n = 1'b1; ld = 1'b0; en = 1'b0;

        step(0, 1, 0, 0);
        check("post_rst_idle", int'(q), 0);
        step(1, 1, 0, 0);
        check("restart_1", int'(q), 1);
        step(1, 1, 0, 0);
        check("restart_2", int'(q), 2);
        check("restart_2_tc", int'(tc), exp_tc(2'd2, 1'b1));
        step(1, 1, 0, 0);
        check("restart_0", int'(q), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
